gray_bin_conv_pipe: RTL and testbench

- Parametrised, pipelined Gray/binary code converter with per-transaction direction select.
- Supersedes the fixed 4-bit combinational Gray-to-binary table.
- valid/ready streaming interface with full backpressure.
- In Gray-to-binary mode, checks that successive Gray words differ in exactly one bit.
- Keeps a saturating error counter for those checks.
- Sits between Gray-coded sources (encoders, async-FIFO pointers) and binary consumers.

---
 rtl/gray_bin_conv_pipe.sv | 130 +++++++++++++
 tb/tb_gray_bin_conv_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined Gray<->binary converter with per-word direction select, valid/ready
// backpressure, Gray single-step checking and a saturating step-error counter.
module gray_bin_conv_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned ERRW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_step_err,
    output logic [ERRW-1:0]  err_cnt
);

    localparam int unsigned LAST = STAGES - 1;
    localparam logic [ERRW-1:0] ERR_MAX = '1;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] sm;
    logic [STAGES-1:0] se;
    logic [WIDTH-1:0]  sd [STAGES];

    logic [WIDTH-1:0]  prev_gray;
    logic              prev_valid;

    logic [WIDTH-1:0]  bin_c;
    logic [WIDTH-1:0]  gray_c;
    logic [WIDTH-1:0]  conv_c;
    logic [WIDTH-1:0]  diff_c;
    logic              onehot_c;
    logic              step_err_c;
    logic              full_tail;
    logic              in_xfer_c;
    logic              out_xfer_c;

    // Conversion and step check in front of stage 0; bin[i] is the parity of g[WIDTH-1:i].
    always_comb begin
        bin_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_c[i] = ^(in_data >> i);
        end
        gray_c     = in_data ^ (in_data >> 1);
        conv_c     = in_mode ? gray_c : bin_c;
        diff_c     = in_data ^ prev_gray;
        onehot_c   = (diff_c != '0) && ((diff_c & (diff_c - WIDTH'(1))) == '0);
        step_err_c = ~in_mode & prev_valid & ~onehot_c;
    end

    // A stage may load when it is empty or anything downstream of it moves.
    always_comb begin
        en        = '0;
        full_tail = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            full_tail = 1'b1;
            for (int j = i; j < STAGES; j++) begin
                full_tail = full_tail & v[j];
            end
            en[i] = out_ready | ~full_tail;
        end
    end

    assign in_ready     = en[0];
    assign in_xfer_c    = in_valid & en[0];
    assign out_xfer_c   = v[LAST] & out_ready;

    assign out_valid    = v[LAST];
    assign out_data     = sd[LAST];
    assign out_mode     = sm[LAST];
    assign out_step_err = se[LAST];

    // Pipeline registers; payload only loads alongside a valid word.
    always_ff @(posedge clk) begin
        if (rst) begin
            v  <= '0;
            sm <= '0;
            se <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sd[i] <= '0;
            end
        end else begin
            if (en[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    sd[0] <= conv_c;
                    sm[0] <= in_mode;
                    se[0] <= step_err_c;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (en[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        sd[i] <= sd[i-1];
                        sm[i] <= sm[i-1];
                        se[i] <= se[i-1];
                    end
                end
            end
        end
    end

    // Last accepted Gray word, used as the reference for the next step check.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray  <= '0;
            prev_valid <= 1'b0;
        end else if (in_xfer_c && !in_mode) begin
            prev_gray  <= in_data;
            prev_valid <= 1'b1;
        end
    end

    // Errors are counted as flagged words leave, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (out_xfer_c && se[LAST] && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERRW'(1);
        end
    end

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Randomised and directed bench for gray_bin_conv_pipe against a queue-based reference model.
module tb_gray_bin_conv_pipe;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_mode;
    logic         out_step_err;
    logic [7:0]   err_cnt;

    logic         s_in_ready;
    logic         s_out_valid;
    logic [W-1:0] s_out_data;
    logic         s_out_mode;
    logic         s_out_step_err;
    logic [1:0]   s_err_cnt;

    always #5 clk = ~clk;

    gray_bin_conv_pipe #(.WIDTH(W), .STAGES(S), .ERRW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_step_err(out_step_err), .err_cnt(err_cnt)
    );

    gray_bin_conv_pipe #(.WIDTH(W), .STAGES(S), .ERRW(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_mode(s_out_mode), .out_step_err(s_out_step_err), .err_cnt(s_err_cnt)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         mode;
        logic         serr;
        int           acc;
    } item_t;

    item_t        q[$];
    logic [W-1:0] got[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_dep = 0;
    logic [W-1:0] m_prev = '0;
    bit           m_prev_v = 1'b0;
    int           m_err8 = 0;
    int           m_err2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Gray->binary as the running XOR of all right shifts; binary->Gray directly.
    function automatic logic [W-1:0] m_conv(input logic [W-1:0] x, input logic m);
        logic [W-1:0] r;
        if (m) return x ^ (x >> 1);
        r = x;
        for (int s = 1; s < W; s++) r = r ^ (x >> s);
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        m_prev   = '0;
        m_prev_v = 1'b0;
        m_err8   = 0;
        m_err2   = 0;
        last_dep = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = W'($urandom);
        in_mode   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        model_clear();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_out_step_err", out_step_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_sat_err_cnt", s_err_cnt, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    // One clock: drive, compare against the model, then advance the model past the edge.
    task automatic cycle(input logic iv, input logic [W-1:0] id, input logic im,
                         input logic ordy, output bit acc);
        bit   exp_ir;
        bit   exp_ov;
        bit   out_x;
        int   hv;
        item_t it;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        in_mode   = im;
        out_ready = ordy;
        #1;
        exp_ir = ordy || (q.size() < S);
        exp_ov = 1'b0;
        if (q.size() > 0) begin
            hv = q[0].acc + S - 1;
            if (last_dep > hv) hv = last_dep;
            exp_ov = (cyc >= hv);
        end
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            check("out_data", out_data, q[0].data);
            check("out_mode", out_mode, q[0].mode);
            check("out_step_err", out_step_err, q[0].serr);
        end
        check("err_cnt", err_cnt, m_err8);
        check("sat_err_cnt", s_err_cnt, m_err2);
        acc   = iv && exp_ir;
        out_x = exp_ov && ordy;
        if (out_x) got.push_back(out_data);
        @(posedge clk);
        cyc++;
        if (out_x) begin
            if (q[0].serr) begin
                if (m_err8 < 255) m_err8++;
                if (m_err2 < 3) m_err2++;
            end
            void'(q.pop_front());
            last_dep = cyc;
        end
        if (acc) begin
            it.data = m_conv(id, im);
            it.mode = im;
            it.serr = !im && m_prev_v && ($countones(id ^ m_prev) != 1);
            it.acc  = cyc;
            q.push_back(it);
            if (!im) begin
                m_prev   = id;
                m_prev_v = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic m, input logic ordy);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, d, m, ordy, acc);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < S + 4; k++) cycle(1'b0, W'($urandom), 1'b0, 1'b1, acc);
    endtask

    task automatic check_got(input string tag, input logic [W-1:0] e[$]);
        check({tag, "_count"}, got.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            check(tag, (i < got.size()) ? got[i] : 8'hxx, e[i]);
    endtask

    initial begin
        logic [W-1:0] e[$];
        logic [W-1:0] bpw[$];
        logic [W-1:0] d;
        bit           acc;
        bit           iv;
        bit           im;
        bit           ordy;
        int           nacc;
        int           k;

        do_reset();

        // Single Gray word, unstalled.
        got.delete();
        send(8'h80, 1'b0, 1'b1);
        drain();
        e = {8'hFF};
        check_got("g80", e);

        // Binary->Gray back to back.
        do_reset();
        got.delete();
        send(8'hFF, 1'b1, 1'b1);
        send(8'h2D, 1'b1, 1'b1);
        drain();
        e = {8'h80, 8'h3B};
        check_got("b2g", e);

        // Gray sequence with two step violations.
        do_reset();
        got.delete();
        e = {8'h00, 8'h01, 8'h03, 8'h02, 8'h07, 8'h07};
        foreach (e[i]) send(e[i], 1'b0, 1'b1);
        drain();
        e = {8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h05};
        check_got("gseq", e);
        check("gseq_err_cnt", err_cnt, 2);

        // Backpressure: only S words fit while the consumer stalls.
        do_reset();
        got.delete();
        bpw  = {8'h01, 8'h02, 8'h03, 8'h04};
        nacc = 0;
        k    = 0;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, bpw[k], 1'b1, 1'b0, acc);
            if (acc) begin nacc++; k++; end
        end
        check("bp_accepted", nacc, S);
        while (k < 4) begin
            send(bpw[k], 1'b1, 1'b1);
            k++;
        end
        drain();
        e = {8'h01, 8'h03, 8'h02, 8'h06};
        check_got("bp", e);

        // Saturation of the narrow counter.
        do_reset();
        send(8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send(8'h5A, 1'b0, 1'b1);
        drain();
        check("sat2_final", s_err_cnt, 3);
        check("sat8_final", err_cnt, 5);

        // Reset with words in flight, then a repeated word must not be flagged.
        do_reset();
        send(8'h10, 1'b0, 1'b0);
        send(8'h10, 1'b0, 1'b0);
        do_reset();
        got.delete();
        send(8'h10, 1'b0, 1'b1);
        drain();
        e = {8'h1F};
        check_got("post_rst", e);
        check("post_rst_err_cnt", err_cnt, 0);

        // Random traffic biased towards valid and invalid Gray steps.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            im   = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       d = W'($urandom);
                3:       d = m_prev;
                default: d = m_prev ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            cycle(iv, d, im, ordy, acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
